// File: rtl/epu_pingpong_buf_if.sv
// Bus-side port bundle between the EPU slave wrapper and the ping-pong buffer.
// The wrapper drives requests through the master modport; read return comes back on rvalid_o/rdata_o.
interface epu_pingpong_buf_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) ();
    logic                  enb_i;
    logic                  cs_i;
    logic                  oe_i;
    logic [DATA_W/8-1:0]   we_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     rdata_o;

    modport master (
        output enb_i, cs_i, oe_i, we_i, addr_i, wdata_i,
        input  rvalid_o, rdata_o
    );

    modport slave (
        input  enb_i, cs_i, oe_i, we_i, addr_i, wdata_i,
        output rvalid_o, rdata_o
    );
endinterface

// File: rtl/epu_pingpong_buf.sv
// Two-bank ping-pong SRAM steering between the EPU bus and the conv engine.
// A mode change is deferred until a fully idle cycle so no access or read return is split across the swap.
module epu_pingpong_buf #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    epu_pingpong_buf_if.slave     bus,
    input  logic                  mode_i,
    input  logic                  conv_cs_i,
    input  logic                  conv_oe_i,
    input  logic [DATA_W/8-1:0]   conv_we_i,
    input  logic [ADDR_W-1:0]     conv_addr_i,
    input  logic [DATA_W-1:0]     conv_wdata_i,
    output logic                  conv_rvalid_o,
    output logic [DATA_W-1:0]     conv_rdata_o,
    output logic                  b0_cs_o,
    output logic                  b0_oe_o,
    output logic [DATA_W/8-1:0]   b0_web_o,
    output logic [ADDR_W-1:0]     b0_addr_o,
    output logic [DATA_W-1:0]     b0_di_o,
    input  logic [DATA_W-1:0]     b0_do_i,
    output logic                  b1_cs_o,
    output logic                  b1_oe_o,
    output logic [DATA_W/8-1:0]   b1_web_o,
    output logic [ADDR_W-1:0]     b1_addr_o,
    output logic [DATA_W-1:0]     b1_di_o,
    input  logic [DATA_W-1:0]     b1_do_i,
    output logic                  mode_o,
    output logic                  swap_pend_o,
    output logic [15:0]           wr_cnt_o
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] ST_NORM = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    typedef struct packed {
        logic              cs;
        logic              oe;
        logic [STRB_W-1:0] web;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] di;
    } bank_port_t;

    logic        bus_acc, bus_wr, bus_rd;
    logic        conv_wr, conv_rd;
    logic        idle, swap;
    bank_port_t  bus_port, conv_port, bank0, bank1;

    logic [0:0]  state_q, state_d;
    logic        mode_q, mode_d;
    logic        rvalid_q, rvalid_d;
    logic        rsel_q, rsel_d;
    logic        conv_rvalid_q, conv_rvalid_d;
    logic        conv_rsel_q, conv_rsel_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // Write wins over read when both strobes and oe are present.
    always_comb begin
        bus_acc = bus.enb_i & bus.cs_i;
        bus_wr  = bus_acc & (|bus.we_i);
        bus_rd  = bus_acc & bus.oe_i & ~(|bus.we_i);
        conv_wr = conv_cs_i & (|conv_we_i);
        conv_rd = conv_cs_i & conv_oe_i & ~(|conv_we_i);
    end

    // NOTE: every field gets a default before the conditional overrides, so no latch can be inferred.
    always_comb begin
        bus_port      = '0;
        bus_port.web  = '1;
        conv_port     = '0;
        conv_port.web = '1;
        if (bus_acc) begin
            bus_port.cs   = 1'b1;
            bus_port.oe   = bus_rd;
            bus_port.web  = bus_wr ? ~bus.we_i : '1;
            bus_port.addr = bus.addr_i;
            bus_port.di   = bus.wdata_i;
        end
        if (conv_cs_i) begin
            conv_port.cs   = 1'b1;
            conv_port.oe   = conv_rd;
            conv_port.web  = conv_wr ? ~conv_we_i : '1;
            conv_port.addr = conv_addr_i;
            conv_port.di   = conv_wdata_i;
        end
    end

    // Bank strobes are gated by reset combinationally so the SRAMs see nothing while rst is low.
    always_comb begin
        bank0     = '0;
        bank0.web = '1;
        bank1     = '0;
        bank1.web = '1;
        if (rst) begin
            if (mode_q) begin
                bank0 = conv_port;
                bank1 = bus_port;
            end else begin
                bank0 = bus_port;
                bank1 = conv_port;
            end
        end
    end

    assign b0_cs_o   = bank0.cs;
    assign b0_oe_o   = bank0.oe;
    assign b0_web_o  = bank0.web;
    assign b0_addr_o = bank0.addr;
    assign b0_di_o   = bank0.di;
    assign b1_cs_o   = bank1.cs;
    assign b1_oe_o   = bank1.oe;
    assign b1_web_o  = bank1.web;
    assign b1_addr_o = bank1.addr;
    assign b1_di_o   = bank1.di;

    // The swap may only happen in a cycle with no traffic and no read data in flight on either side.
    always_comb begin
        idle    = ~bus_acc & ~conv_cs_i & ~rvalid_q & ~conv_rvalid_q;
        swap    = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_NORM: if (mode_i != mode_q) state_d = ST_PEND;
            ST_PEND: begin
                if (mode_i == mode_q) begin
                    state_d = ST_NORM;
                end else if (idle) begin
                    state_d = ST_NORM;
                    swap    = 1'b1;
                end
            end
            default: state_d = ST_NORM;
        endcase
        mode_d = mode_q ^ swap;
    end

    always_comb begin
        rvalid_d      = bus_rd;
        rsel_d        = mode_q;
        conv_rvalid_d = conv_rd;
        conv_rsel_d   = ~mode_q;
        wr_cnt_d      = wr_cnt_q;
        if (swap) begin
            wr_cnt_d = '0;
        end else if (bus_wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // NOTE: state flops use non-blocking assignment and an asynchronous active-low clear; the SRAM banks themselves are external and never reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_NORM;
            mode_q        <= 1'b0;
            rvalid_q      <= 1'b0;
            rsel_q        <= 1'b0;
            conv_rvalid_q <= 1'b0;
            conv_rsel_q   <= 1'b0;
            wr_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rvalid_q      <= rvalid_d;
            rsel_q        <= rsel_d;
            conv_rvalid_q <= conv_rvalid_d;
            conv_rsel_q   <= conv_rsel_d;
            wr_cnt_q      <= wr_cnt_d;
        end
    end

    // Return data comes from the bank latched at issue, and is held at zero when not valid.
    always_comb begin
        bus.rvalid_o  = rvalid_q;
        bus.rdata_o   = '0;
        conv_rvalid_o = conv_rvalid_q;
        conv_rdata_o  = '0;
        if (rvalid_q)      bus.rdata_o  = rsel_q ? b1_do_i : b0_do_i;
        if (conv_rvalid_q) conv_rdata_o = conv_rsel_q ? b1_do_i : b0_do_i;
    end

    assign mode_o      = mode_q;
    assign swap_pend_o = (state_q == ST_PEND);
    assign wr_cnt_o    = wr_cnt_q;
endmodule

// File: tb/tb_epu_pingpong_buf.sv
// Self-checking bench for epu_pingpong_buf: directed scenarios plus a randomized phase,
// checked against a transaction-level model of two word-addressed banks and the deferred-swap rule.
module tb_epu_pingpong_buf;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_i;
    logic          conv_cs_i, conv_oe_i;
    logic [SW-1:0] conv_we_i;
    logic [AW-1:0] conv_addr_i;
    logic [DW-1:0] conv_wdata_i;
    logic          conv_rvalid_o;
    logic [DW-1:0] conv_rdata_o;
    logic          b0_cs_o, b0_oe_o, b1_cs_o, b1_oe_o;
    logic [SW-1:0] b0_web_o, b1_web_o;
    logic [AW-1:0] b0_addr_o, b1_addr_o;
    logic [DW-1:0] b0_di_o, b1_di_o, b0_do, b1_do;
    logic          mode_o, swap_pend_o;
    logic [15:0]   wr_cnt_o;

    epu_pingpong_buf_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    epu_pingpong_buf #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .mode_i(mode_i),
        .conv_cs_i(conv_cs_i), .conv_oe_i(conv_oe_i), .conv_we_i(conv_we_i),
        .conv_addr_i(conv_addr_i), .conv_wdata_i(conv_wdata_i),
        .conv_rvalid_o(conv_rvalid_o), .conv_rdata_o(conv_rdata_o),
        .b0_cs_o(b0_cs_o), .b0_oe_o(b0_oe_o), .b0_web_o(b0_web_o), .b0_addr_o(b0_addr_o),
        .b0_di_o(b0_di_o), .b0_do_i(b0_do),
        .b1_cs_o(b1_cs_o), .b1_oe_o(b1_oe_o), .b1_web_o(b1_web_o), .b1_addr_o(b1_addr_o),
        .b1_di_o(b1_di_o), .b1_do_i(b1_do),
        .mode_o(mode_o), .swap_pend_o(swap_pend_o), .wr_cnt_o(wr_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Byte-lane merge: lane i of new data replaces the old word when strobe bit i is set.
    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nd, logic [SW-1:0] stb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (stb[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    // Behavioural synchronous SRAMs on the bank ports (one-cycle read, active-low byte writes).
    logic [DW-1:0] sram0 [int];
    logic [DW-1:0] sram1 [int];
    always @(posedge clk) begin
        if (b0_cs_o) begin
            if (b0_oe_o) b0_do <= sram0.exists(int'(b0_addr_o)) ? sram0[int'(b0_addr_o)] : '0;
            if (b0_web_o != '1)
                sram0[int'(b0_addr_o)] = merge(sram0.exists(int'(b0_addr_o)) ? sram0[int'(b0_addr_o)] : '0, b0_di_o, ~b0_web_o);
        end
        if (b1_cs_o) begin
            if (b1_oe_o) b1_do <= sram1.exists(int'(b1_addr_o)) ? sram1[int'(b1_addr_o)] : '0;
            if (b1_web_o != '1)
                sram1[int'(b1_addr_o)] = merge(sram1.exists(int'(b1_addr_o)) ? sram1[int'(b1_addr_o)] : '0, b1_di_o, ~b1_web_o);
        end
    end

    // Reference model: expected bank contents and the externally visible state.
    logic [DW-1:0] ref0 [int];
    logic [DW-1:0] ref1 [int];
    logic          m_mode, m_pend, m_rv, m_crv;
    logic [15:0]   m_cnt;
    logic [DW-1:0] m_rdata, m_cdata;

    function automatic logic [DW-1:0] ref_rd(logic k, int a);
        if (k) return ref1.exists(a) ? ref1[a] : '0;
        return ref0.exists(a) ? ref0[a] : '0;
    endfunction

    task automatic ref_wr(logic k, int a, logic [DW-1:0] d, logic [SW-1:0] we);
        if (k) ref1[a] = merge(ref_rd(1'b1, a), d, we);
        else   ref0[a] = merge(ref_rd(1'b0, a), d, we);
    endtask

    task automatic model_reset();
        m_mode = 1'b0; m_pend = 1'b0; m_rv = 1'b0; m_crv = 1'b0;
        m_cnt = '0; m_rdata = '0; m_cdata = '0;
    endtask

    task automatic model_edge();
        logic bacc, bwr, brd, cwr, crd, quiet, toggle;
        if (!rst) begin
            model_reset();
            return;
        end
        bacc  = bus_if.enb_i && bus_if.cs_i;
        bwr   = bacc && (bus_if.we_i != 0);
        brd   = bacc && bus_if.oe_i && (bus_if.we_i == 0);
        cwr   = conv_cs_i && (conv_we_i != 0);
        crd   = conv_cs_i && conv_oe_i && (conv_we_i == 0);
        quiet = !bacc && !conv_cs_i && !m_rv && !m_crv;
        toggle = m_pend && (mode_i != m_mode) && quiet;
        // Bus owns bank m_mode, conv owns the other one.
        m_rv    = brd;
        m_rdata = brd ? ref_rd(m_mode, int'(bus_if.addr_i)) : '0;
        m_crv   = crd;
        m_cdata = crd ? ref_rd(!m_mode, int'(conv_addr_i)) : '0;
        if (bwr) ref_wr(m_mode, int'(bus_if.addr_i), bus_if.wdata_i, bus_if.we_i);
        if (cwr) ref_wr(!m_mode, int'(conv_addr_i), conv_wdata_i, conv_we_i);
        if (toggle) m_cnt = '0;
        else if (bwr && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!m_pend) m_pend = (mode_i != m_mode);
        else if (mode_i == m_mode || toggle) m_pend = 1'b0;
        if (toggle) m_mode = !m_mode;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank(logic k, logic cs, logic oe, logic [SW-1:0] web, logic [AW-1:0] addr, logic [DW-1:0] di);
        logic          acc, o;
        logic [SW-1:0] we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e_cs, e_oe;
        logic [SW-1:0] e_web;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_di;
        if (k == m_mode) begin
            acc = bus_if.enb_i && bus_if.cs_i; o = bus_if.oe_i; we = bus_if.we_i;
            a = bus_if.addr_i; d = bus_if.wdata_i;
        end else begin
            acc = conv_cs_i; o = conv_oe_i; we = conv_we_i; a = conv_addr_i; d = conv_wdata_i;
        end
        e_cs = 1'b0; e_oe = 1'b0; e_web = '1; e_addr = '0; e_di = '0;
        if (rst && acc) begin
            e_cs = 1'b1; e_oe = o && (we == 0); e_web = (we != 0) ? ~we : '1; e_addr = a; e_di = d;
        end
        check($sformatf("b%0d_cs", k), cs, e_cs);
        check($sformatf("b%0d_oe", k), oe, e_oe);
        check($sformatf("b%0d_web", k), web, e_web);
        check($sformatf("b%0d_addr", k), addr, e_addr);
        check($sformatf("b%0d_di", k), di, e_di);
    endtask

    task automatic check_all();
        check("rvalid", bus_if.rvalid_o, m_rv);
        check("rdata", bus_if.rdata_o, m_rdata);
        check("conv_rvalid", conv_rvalid_o, m_crv);
        check("conv_rdata", conv_rdata_o, m_cdata);
        check("mode_o", mode_o, m_mode);
        check("swap_pend", swap_pend_o, m_pend);
        check("wr_cnt", wr_cnt_o, m_cnt);
        check_bank(1'b0, b0_cs_o, b0_oe_o, b0_web_o, b0_addr_o, b0_di_o);
        check_bank(1'b1, b1_cs_o, b1_oe_o, b1_web_o, b1_addr_o, b1_di_o);
    endtask

    // One clock: check settled outputs mid-cycle, then advance the model on the edge.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_bus(logic enb, logic cs, logic oe, logic [SW-1:0] we, logic [AW-1:0] a, logic [DW-1:0] d);
        bus_if.enb_i = enb; bus_if.cs_i = cs; bus_if.oe_i = oe;
        bus_if.we_i = we; bus_if.addr_i = a; bus_if.wdata_i = d;
    endtask

    task automatic set_conv(logic cs, logic oe, logic [SW-1:0] we, logic [AW-1:0] a, logic [DW-1:0] d);
        conv_cs_i = cs; conv_oe_i = oe; conv_we_i = we; conv_addr_i = a; conv_wdata_i = d;
    endtask

    task automatic set_idle();
        set_bus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_conv(1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mode_i = 1'b0;
        set_idle();
        model_reset();
        cyc();
        cyc();
        check("reset_mode", mode_o, 64'd0);
        check("reset_cnt", wr_cnt_o, 64'd0);
        rst = 1'b1;
        cyc();

        // Bus write then read-back at 0x10 in mode 0.
        set_bus(1'b1, 1'b1, 1'b0, 4'hF, 14'h10, 32'hA5A5_0001);
        #1;
        check("wr_b0_cs", b0_cs_o, 64'd1);
        check("wr_b0_web", b0_web_o, 64'd0);
        check("wr_b0_addr", b0_addr_o, 64'h10);
        check("wr_b0_di", b0_di_o, 64'hA5A5_0001);
        cyc();
        set_bus(1'b1, 1'b1, 1'b1, 4'h0, 14'h10, '0);
        cyc();
        check("rd_rvalid", bus_if.rvalid_o, 64'd1);
        check("rd_rdata", bus_if.rdata_o, 64'hA5A5_0001);
        check("rd_wr_cnt", wr_cnt_o, 64'd1);

        // Mode request while the bus reads every cycle: swap waits for a quiet cycle.
        mode_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("pend_held", swap_pend_o, 64'd1);
            check("pend_mode", mode_o, 64'd0);
        end
        set_idle();
        cyc();
        check("tail_rvalid_mode", mode_o, 64'd0);
        cyc();
        check("swap_mode", mode_o, 64'd1);
        check("swap_pend_clr", swap_pend_o, 64'd0);
        check("swap_cnt_clr", wr_cnt_o, 64'd0);

        // Conv side now owns bank0 and sees the earlier bus write.
        set_conv(1'b1, 1'b1, '0, 14'h10, '0);
        cyc();
        check("conv_rvalid", conv_rvalid_o, 64'd1);
        check("conv_rdata", conv_rdata_o, 64'hA5A5_0001);
        set_idle();

        // Write wins over oe: partial strobes, no read return.
        set_bus(1'b1, 1'b1, 1'b1, 4'b0011, 14'h20, 32'h1234_5678);
        #1;
        check("wpri_web", b1_web_o, 64'b1100);
        check("wpri_oe", b1_oe_o, 64'd0);
        cyc();
        check("wpri_rvalid", bus_if.rvalid_o, 64'd0);

        // Bus enable low masks the access entirely.
        set_bus(1'b0, 1'b1, 1'b1, '0, 14'h20, '0);
        #1;
        check("enb0_b1_cs", b1_cs_o, 64'd0);
        check("enb0_b0_cs", b0_cs_o, 64'd0);
        cyc();
        check("enb0_rvalid", bus_if.rvalid_o, 64'd0);
        check("enb0_rdata", bus_if.rdata_o, 64'd0);

        // Randomized traffic on both sides with occasional mode requests.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_idle();
            end else begin
                set_bus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 1) != 0) ? SW'($urandom) : '0, AW'($urandom_range(0, 15)), $urandom);
                set_conv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 1) != 0) ? SW'($urandom) : '0, AW'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 19) == 0) mode_i = !mode_i;
            cyc();
        end

        // Bring the design to mode 1 with exactly five bus writes counted.
        set_idle();
        mode_i = 1'b0;
        for (int i = 0; i < 8 && (m_mode != 1'b0 || m_pend); i++) cyc();
        mode_i = 1'b1;
        for (int i = 0; i < 8 && m_mode != 1'b1; i++) cyc();
        check("pre_rst_mode", mode_o, 64'd1);
        check("pre_rst_cnt0", wr_cnt_o, 64'd0);
        for (int i = 0; i < 5; i++) begin
            set_bus(1'b1, 1'b1, 1'b0, 4'hF, AW'(14'h30 + i), $urandom);
            cyc();
        end
        check("pre_rst_cnt5", wr_cnt_o, 64'd5);

        // Reset lands in the middle of a bus read.
        set_bus(1'b1, 1'b1, 1'b1, '0, 14'h30, '0);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_b1_cs", b1_cs_o, 64'd0);
        check("rst_b1_oe", b1_oe_o, 64'd0);
        check("rst_b1_web", b1_web_o, 64'hF);
        check("rst_b0_cs", b0_cs_o, 64'd0);
        cyc();
        set_idle();
        mode_i = 1'b0;
        rst = 1'b1;
        cyc();
        check("post_rst_rvalid", bus_if.rvalid_o, 64'd0);
        check("post_rst_mode", mode_o, 64'd0);
        check("post_rst_cnt", wr_cnt_o, 64'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
